// File: rtl/data_mem_mc.sv
// Multi-cycle data memory with branch-resolution mux: an access is accepted in
// IDLE, spends LATENCY cycles in BUSY, and signals completion with a DONE pulse.
module data_mem_mc #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             zero,
  input  logic             ltz,
  input  logic             Branch,
  input  logic [1:0]       branch_op,
  input  logic [WIDTH-1:0] branchAddr,
  input  logic [WIDTH-1:0] pc,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             halt,
  input  logic [WIDTH-1:0] ALU_result,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] branch_or_pc,
  output logic [WIDTH-1:0] readData,
  output logic             stall,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] LAT_CNT = LATENCY[3:0];

  state_t                 state;
  logic [3:0]             cnt;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [WIDTH-1:0]       wdata_q;
  logic                   op_wr_q;
  logic [WIDTH-1:0]       mem [0:(1<<ADDR_BITS)-1];

  logic cond;
  logic to_branch;
  logic req;
  logic mem_we;
  logic unused_addr_hi;

  always_comb begin
    cond = 1'b0;
    case (branch_op)
      2'b00:   cond = zero;
      2'b01:   cond = ~zero;
      2'b10:   cond = ltz;
      default: cond = ~ltz;
    endcase
  end

  assign to_branch      = Branch & cond;
  assign branch_or_pc   = to_branch ? branchAddr : pc;
  assign req            = (MemRead | MemWrite) & ~halt;
  assign stall          = ((state == IDLE) & req) | (state == BUSY);
  assign mem_we         = (state == BUSY) && (cnt == 4'd1) && op_wr_q;
  // Upper address bits wrap silently.
  assign unused_addr_hi = ^ALU_result[WIDTH-1:ADDR_BITS];

  // The array is deliberately unreset; a reset mid-access never reaches the
  // write edge because state is cleared asynchronously.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      readData <= '0;
      done     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      op_wr_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            idx_q   <= ALU_result[ADDR_BITS-1:0];
            wdata_q <= writedata;
            op_wr_q <= MemWrite;
            cnt     <= LAT_CNT;
            state   <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (!op_wr_q) readData <= mem[idx_q];
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_mc.sv
// Randomized scoreboard bench for data_mem_mc: the driver pushes expected load
// results, a negedge monitor pops and checks them on each done pulse.
module tb_data_mem_mc;
  localparam int WIDTH     = 16;
  localparam int ADDR_BITS = 8;
  localparam int LATENCY   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             zero, ltz, Branch;
  logic [1:0]       branch_op;
  logic [WIDTH-1:0] branchAddr, pc;
  logic             MemRead, MemWrite, halt;
  logic [WIDTH-1:0] ALU_result, writedata;
  logic [WIDTH-1:0] branch_or_pc, readData;
  logic             stall, done;

  data_mem_mc #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .zero(zero), .ltz(ltz), .Branch(Branch),
    .branch_op(branch_op), .branchAddr(branchAddr), .pc(pc),
    .MemRead(MemRead), .MemWrite(MemWrite), .halt(halt),
    .ALU_result(ALU_result), .writedata(writedata),
    .branch_or_pc(branch_or_pc), .readData(readData),
    .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int stall_run = 0;

  logic [15:0] mm [256];
  logic [15:0] model_rd = 16'h0000;
  logic [15:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    MemRead = 1'b0; MemWrite = 1'b0; halt = 1'b0;
    ALU_result = '0; writedata = '0;
  endtask

  // Issue one access, then scramble all memory inputs through BUSY and DONE.
  task automatic issue(input logic wr, input logic rd, input logic [15:0] addr,
                       input logic [15:0] data, input bit force_halt);
    int idx;
    @(posedge clk); #1;
    MemWrite = wr; MemRead = rd; ALU_result = addr; writedata = data; halt = 1'b0;
    idx = int'(addr) % 256;
    if (wr) mm[idx] = data;
    else    model_rd = mm[idx];
    exp_q.push_back(model_rd);
    repeat (LATENCY + 1) begin
      @(posedge clk); #1;
      MemRead    = 1'($urandom);
      MemWrite   = 1'($urandom);
      ALU_result = 16'($urandom);
      writedata  = 16'($urandom);
      halt       = force_halt ? 1'b1 : 1'($urandom);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic br_check(input logic b, input logic [1:0] op, input logic z,
                          input logic l, input logic [15:0] ba, input logic [15:0] p);
    logic taken;
    Branch = b; branch_op = op; zero = z; ltz = l; branchAddr = ba; pc = p;
    case (op)
      2'b00:   taken = z;
      2'b01:   taken = !z;
      2'b10:   taken = l;
      default: taken = !l;
    endcase
    #1;
    chk("branch_or_pc", 32'(branch_or_pc), 32'((b && taken) ? ba : p));
  endtask

  // Monitor: count stall cycles per access and score each done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      stall_run = 0;
    end else begin
      if (stall) stall_run++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          chk("readData", 32'(readData), 32'(exp_q.pop_front()));
          chk("stall_cycles", 32'(stall_run), 32'(LATENCY + 1));
        end
        stall_run = 0;
      end
    end
  end

  initial begin
    idle_inputs();
    Branch = 1'b0; branch_op = 2'b00; zero = 1'b0; ltz = 1'b0;
    branchAddr = '0; pc = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_readData", 32'(readData), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall_idle", 32'(stall), 32'd0);
    MemRead = 1'b1; #1;
    chk("rst_stall_req", 32'(stall), 32'd1);
    MemRead = 1'b0; #1;
    @(posedge clk); #1;
    rst = 1'b1;

    br_check(1'b1, 2'b11, 1'b0, 1'b0, 16'h0100, 16'h0042);
    br_check(1'b1, 2'b11, 1'b0, 1'b1, 16'h0100, 16'h0042);
    for (int i = 0; i < 40; i++)
      br_check(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
               16'($urandom), 16'($urandom));

    for (int i = 0; i < 256; i++)
      issue(1'b1, 1'b0, 16'(i), 16'($urandom), 1'b0);

    issue(1'b1, 1'b0, 16'h0034, 16'hBEEF, 1'b0);
    issue(1'b0, 1'b1, 16'h0034, 16'h0000, 1'b0);
    issue(1'b1, 1'b0, 16'h0034, 16'h1234, 1'b0);
    issue(1'b0, 1'b1, 16'h0134, 16'h0000, 1'b0);
    issue(1'b1, 1'b1, 16'h0010, 16'h5555, 1'b0);
    issue(1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0);

    // Reset lands while a write of 0xAAAA is in BUSY.
    issue(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
    issue(1'b0, 1'b1, 16'h0034, 16'h0000, 1'b0);
    @(posedge clk); #1;
    MemWrite = 1'b1; ALU_result = 16'h0020; writedata = 16'hAAAA;
    @(posedge clk); #1;
    chk("busy_stall", 32'(stall), 32'd1);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("async_rst_stall", 32'(stall), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_readData", 32'(readData), 32'd0);
    model_rd = 16'h0000;
    @(posedge clk); #1;
    rst = 1'b1;
    issue(1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0);

    // halt in IDLE blocks the request entirely.
    @(posedge clk); #1;
    halt = 1'b1; MemRead = 1'b1; ALU_result = 16'h0034;
    repeat (4) begin
      @(negedge clk);
      chk("halt_idle_stall", 32'(stall), 32'd0);
      chk("halt_idle_done", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    idle_inputs();
    issue(1'b0, 1'b1, 16'h0020, 16'h0000, 1'b1);

    for (int i = 0; i < 150; i++) begin
      int op;
      op = int'($urandom_range(2, 0));
      issue(op != 0, op != 1, 16'($urandom), 16'($urandom), 1'b0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("pending_done", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_mc.md
DATA_MEM_MC -- requirements
Module: data_mem_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning datapath width of PC, address and data.
REQ-002 SHALL have parameter ADDR_BITS, default 8, meaning word-address bits; the array holds 2^ADDR_BITS words of WIDTH bits.
REQ-003 SHALL have parameter LATENCY, default 2, meaning BUSY cycles per access; legal range 1..15.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- zero  in  1  ALU result equals zero.
- ltz  in  1  ALU result less than zero.
- Branch  in  1  branch instruction, from control.
- branch_op  in  2  branch condition select.
- branchAddr  in  WIDTH  branch target.
- pc  in  WIDTH  sequential next PC.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- halt  in  1  halt; blocks new accesses.
- ALU_result  in  WIDTH  access address.
- writedata  in  WIDTH  store data.
- branch_or_pc  out  WIDTH  next PC.
- readData  out  WIDTH  load result.
- stall  out  1  pipeline must hold.
- done  out  1  access completed this cycle.

Function
REQ-006 SHALL decode branch_op as: 00 taken if zero; 01 taken if ~zero; 10 taken if ltz; 11 taken if ~ltz.
REQ-007 SHALL compute toBranch = Branch & condition, combinationally; branch_or_pc = toBranch ? branchAddr : pc, with zero latency and independent of FSM state.
REQ-008 SHALL define req = (MemRead | MemWrite) & ~halt; if both MemRead and MemWrite are high the access SHALL be a write.
REQ-009 SHALL use word index = ALU_result[ADDR_BITS-1:0]; upper address bits are ignored (wrap-around, no error).
REQ-010 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-011 In IDLE with req=1, SHALL capture index, writedata and op, load counter = LATENCY, and go to BUSY; with req=0, SHALL stay in IDLE.
REQ-012 In BUSY, SHALL decrement the counter each cycle; when counter==1, SHALL perform the access at the clock edge (write array, or load readData from the array) and go to DONE.
REQ-013 In DONE, SHALL go to IDLE unconditionally; a request present in DONE is not accepted.
REQ-014 stall SHALL be combinational: 1 when (state==IDLE & req) or state==BUSY; 0 otherwise.
REQ-015 done SHALL be 1 only in DONE (one-cycle pulse).
REQ-016 A single access SHALL hold stall for LATENCY+1 cycles, followed by exactly one done cycle.
REQ-017 Inputs SHALL be ignored during BUSY/DONE; captured values govern the access.
REQ-018 readData SHALL be registered, SHALL update only on read completion, and SHALL hold otherwise (including across writes).
REQ-019 halt rising during BUSY SHALL NOT abort the in-flight access; the access completes normally.
REQ-020 halt=1 in IDLE SHALL prevent any new access and hold stall=0.

Reset
REQ-021 rst=0 SHALL immediately force state=IDLE, counter=0, readData=0, done=0; stall then follows REQ-014.
REQ-022 Reset during BUSY SHALL discard the in-flight access; no array write occurs.
REQ-023 Array contents SHALL NOT be reset.

Verification (WIDTH=16, ADDR_BITS=8, LATENCY=2)
REQ-024 Write 0xBEEF to 0x0034, then read 0x0034 -> stall high 3 cycles per access, done pulses once per access, readData=0xBEEF after the read's done.
REQ-025 Branch=1, branch_op=11, ltz=0, branchAddr=0x0100, pc=0x0042 -> branch_or_pc=0x0100; ltz=1 -> 0x0042, same cycle.
REQ-026 Read 0x0134 after writing 0x1234 to 0x0034 -> readData=0x1234 (wrap-around).
REQ-027 MemRead=MemWrite=1, writedata=0x5555, addr 0x0010 -> location written, readData unchanged.
REQ-028 Write 0xAAAA to 0x0020 is in BUSY when rst=0 -> state IDLE immediately; a later read of 0x0020 does not return 0xAAAA (prior value 0x0000 preloaded).
REQ-029 halt=1 with MemRead=1 in IDLE -> stall=0, no done; halt asserted mid-BUSY -> access completes, done pulses.
